// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle control unit for the MIPS-lite core. Walks each instruction
// through fetch, decode, execute, memory and writeback states and drives
// every datapath enable, mux select and ALU operation from the registered
// state. Memory accesses stall on a one-bit ready handshake, retired
// instructions are counted and a halt opcode parks the machine.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_opcode       IR[31:26]
//   i_funct        IR[5:0]
//   i_zero         ALU zero flag, used in BRANCH
//   i_mem_ready    memory finished the current access this cycle
//   o_pc_en        PC load enable
//   o_iord         memory address select (0 PC, 1 ALUOut)
//   o_mem_read     memory read request
//   o_mem_write    memory write request
//   o_ir_write     IR load
//   o_reg_dst      register write address (0 rt, 1 rd)
//   o_mem_to_reg   register write data (0 ALUOut, 1 MDR)
//   o_reg_write    register file write enable
//   o_alu_src_a    ALU A select (0 PC, 1 A)
//   o_alu_src_b    ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   o_alu_ctrl     ALU operation
//   o_pc_source    PC next-value select (00 ALU, 01 ALUOut, 10 jump)
//   o_state        current state for debug
//   o_illegal      one-cycle pulse on unsupported opcode/funct
//   o_halted       sticky halt indication
//   o_instr_count  retired instruction count
module mips_multicycle_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_pc_en,
  output logic        o_iord,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_ir_write,
  output logic        o_reg_dst,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [2:0]  o_alu_ctrl,
  output logic [1:0]  o_pc_source,
  output logic [3:0]  o_state,
  output logic        o_illegal,
  output logic        o_halted,
  output logic [31:0] o_instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_halted;
  logic [31:0] r_instrCount;
  logic [2:0]  w_functAlu;
  logic        w_functKnown;
  logic        w_retire;

  // R-type funct decode, shared by EXEC and ALUWB so the ALU operation
  // stays put across the writeback cycle.
  always_comb begin
    w_functAlu   = ALU_ADD;
    w_functKnown = 1'b1;
    case (i_funct)
      6'h20, 6'h21: w_functAlu = ALU_ADD;
      6'h22, 6'h23: w_functAlu = ALU_SUB;
      6'h24:        w_functAlu = ALU_AND;
      6'h25:        w_functAlu = ALU_OR;
      6'h2A:        w_functAlu = ALU_SLT;
      default: begin
        w_functAlu   = ALU_AND;
        w_functKnown = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Unused codes fall back to FETCH.
  always_comb begin
    w_nextState = FETCH;
    case (r_state)
      FETCH:  w_nextState = i_mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: w_nextState = MEMADR;
          OP_R:         w_nextState = EXEC;
          OP_BEQ:       w_nextState = BRANCH;
          OP_J:         w_nextState = JUMP;
          OP_ADDI:      w_nextState = ADDIEX;
          OP_HALT:      w_nextState = HALT;
          default:      w_nextState = FETCH;
        endcase
      end
      MEMADR: w_nextState = (i_opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  w_nextState = i_mem_ready ? MEMWB : MEMRD;
      MEMWB:  w_nextState = FETCH;
      MEMWR:  w_nextState = i_mem_ready ? FETCH : MEMWR;
      EXEC:   w_nextState = w_functKnown ? ALUWB : FETCH;
      ALUWB:  w_nextState = FETCH;
      BRANCH: w_nextState = FETCH;
      JUMP:   w_nextState = FETCH;
      ADDIEX: w_nextState = ADDIWB;
      ADDIWB: w_nextState = FETCH;
      HALT:   w_nextState = HALT;
      default: w_nextState = FETCH;
    endcase
  end

  // Moore outputs from the registered state; only the FETCH handshake,
  // the branch zero gate and the illegal pulse look at live inputs.
  // Reset forces every control output low regardless of state.
  always_comb begin
    o_pc_en      = 1'b0;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    o_alu_ctrl   = 3'b000;
    o_pc_source  = 2'b00;
    o_illegal    = 1'b0;
    if (!i_rst) begin
      case (r_state)
        FETCH: begin
          o_mem_read  = 1'b1;
          o_alu_src_b = 2'b01;
          o_alu_ctrl  = ALU_ADD;
          o_pc_en     = i_mem_ready;
          o_ir_write  = i_mem_ready;
        end
        DECODE: begin
          o_alu_src_b = 2'b11;
          o_alu_ctrl  = ALU_ADD;
          case (i_opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_HALT: o_illegal = 1'b0;
            default: o_illegal = 1'b1;
          endcase
        end
        MEMADR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
          o_alu_ctrl  = ALU_ADD;
        end
        MEMRD: begin
          o_mem_read = 1'b1;
          o_iord     = 1'b1;
        end
        MEMWB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
        end
        MEMWR: begin
          o_mem_write = 1'b1;
          o_iord      = 1'b1;
        end
        EXEC: begin
          o_alu_src_a = 1'b1;
          o_alu_ctrl  = w_functAlu;
          o_illegal   = !w_functKnown;
        end
        ALUWB: begin
          o_reg_write = 1'b1;
          o_reg_dst   = 1'b1;
          o_alu_ctrl  = w_functAlu;
        end
        BRANCH: begin
          o_alu_src_a = 1'b1;
          o_alu_ctrl  = ALU_SUB;
          o_pc_source = 2'b01;
          o_pc_en     = i_zero;
        end
        JUMP: begin
          o_pc_source = 2'b10;
          o_pc_en     = 1'b1;
        end
        ADDIEX: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
          o_alu_ctrl  = ALU_ADD;
        end
        ADDIWB: begin
          o_reg_write = 1'b1;
        end
        default: begin
          o_pc_en = 1'b0;
        end
      endcase
    end
  end

  // An instruction retires on its final cycle back into FETCH; illegal
  // exits from DECODE/EXEC and HALT never count.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: w_retire = 1'b1;
      MEMWR:   w_retire = i_mem_ready;
      default: w_retire = 1'b0;
    endcase
  end

  // Retired-instruction counter (wraps naturally) and sticky halt flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instrCount <= 32'd0;
      r_halted     <= 1'b0;
    end else begin
      if (w_retire) begin
        r_instrCount <= r_instrCount + 32'd1;
      end
      if (w_nextState == HALT) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign o_state       = r_state;
  assign o_halted      = r_halted;
  assign o_instr_count = r_instrCount;

endmodule
